// File: rtl/dmem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dmem_arbiter                                                  |
// | Purpose  : Two-requester (CPU/DMA) data-memory arbiter with DMA          |
// |            starvation guard and per-requester read/error responses.      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module dmem_arbiter #(
  parameter int DEPTH    = 128,
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_req,
  input  logic        r0_we,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  output logic        r0_gnt,
  output logic        r0_rvalid,
  output logic [31:0] r0_rdata,
  output logic        r0_err,
  input  logic        r1_req,
  input  logic        r1_we,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  output logic        r1_gnt,
  output logic        r1_rvalid,
  output logic [31:0] r1_rdata,
  output logic        r1_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int               WCW        = ($clog2(MAX_WAIT + 1) > 3) ? $clog2(MAX_WAIT + 1) : 3;
  localparam logic [WCW-1:0]   C_MAX_WAIT = WCW'(MAX_WAIT);
  localparam logic [WCW-1:0]   C_ONE      = WCW'(1);
  localparam logic [31:0]      C_DEPTH    = 32'(DEPTH);

  logic [WCW-1:0] r_wait_cnt;
  logic           r_rd0;
  logic           r_err0;
  logic           r_rd1;
  logic           r_err1;

  logic           w_force1;
  logic           w_gnt0;
  logic           w_gnt1;
  logic           w_in0;
  logic           w_in1;

  // DMA is forced through once it has waited MAX_WAIT cycles; grants are
  // blocked entirely while reset is asserted.
  always_comb begin
    w_force1 = r1_req && (r_wait_cnt == C_MAX_WAIT);
    w_gnt1   = !rst && r1_req && (w_force1 || !r0_req);
    w_gnt0   = !rst && r0_req && !w_force1;
    w_in0    = (r0_addr < C_DEPTH);
    w_in1    = (r1_addr < C_DEPTH);
  end

  assign r0_gnt = w_gnt0;
  assign r1_gnt = w_gnt1;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_gnt0 && w_in0) begin
      mem_en    = 1'b1;
      mem_we    = r0_we;
      mem_addr  = r0_addr;
      mem_wdata = r0_wdata;
    end else if (w_gnt1 && w_in1) begin
      mem_en    = 1'b1;
      mem_we    = r1_we;
      mem_addr  = r1_addr;
      mem_wdata = r1_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= '0;
      r_rd0      <= 1'b0;
      r_err0     <= 1'b0;
      r_rd1      <= 1'b0;
      r_err1     <= 1'b0;
    end else begin
      if (r1_req && !w_gnt1) begin
        if (r_wait_cnt != C_MAX_WAIT) begin
          r_wait_cnt <= r_wait_cnt + C_ONE;
        end
      end else begin
        r_wait_cnt <= '0;
      end
      // One-deep response tracking: read issued and out-of-range status.
      r_rd0  <= w_gnt0 && !r0_we;
      r_err0 <= w_gnt0 && !w_in0;
      r_rd1  <= w_gnt1 && !r1_we;
      r_err1 <= w_gnt1 && !w_in1;
    end
  end

  // Out-of-range reads respond with zero data instead of the memory output.
  assign r0_rvalid = r_rd0;
  assign r0_err    = r_err0;
  assign r0_rdata  = (r_rd0 && !r_err0) ? mem_rdata : '0;
  assign r1_rvalid = r_rd1;
  assign r1_err    = r_err1;
  assign r1_rdata  = (r_rd1 && !r_err1) ? mem_rdata : '0;

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DEPTH, default 128: number of 32-bit words in the shared data memory; valid word addresses are 0..DEPTH-1.
REQ-002 Parameter MAX_WAIT, default 4: maximum consecutive cycles requester 1 may be denied while requesting.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 r0_req  in  1  CPU (requester 0) access request; held until granted.
REQ-006 r0_we  in  1  requester 0 write (1) / read (0).
REQ-007 r0_addr  in  32  requester 0 word address.
REQ-008 r0_wdata  in  32  requester 0 write data.
REQ-009 r0_gnt  out  1  requester 0 granted this cycle; transfer occurs when r0_req and r0_gnt are both 1.
REQ-010 r0_rvalid  out  1  requester 0 read response valid.
REQ-011 r0_rdata  out  32  requester 0 read data; 0 when r0_rvalid is 0.
REQ-012 r0_err  out  1  requester 0 out-of-range access error pulse.
REQ-013 r1_req, r1_we, r1_addr, r1_wdata, r1_gnt, r1_rvalid, r1_rdata, r1_err: DMA (requester 1) ports, same directions, widths and meanings as REQ-005..REQ-012.
REQ-014 mem_en  out  1  memory access strobe.
REQ-015 mem_we  out  1  memory write enable (WE2 of the memory).
REQ-016 mem_addr  out  32  memory address.
REQ-017 mem_wdata  out  32  memory write data.
REQ-018 mem_rdata  in  32  memory read data; registered by the memory, valid the cycle after a read is presented.

Function
REQ-019 Arbitration is combinational within a cycle: at most one of r0_gnt/r1_gnt is 1; a grant is given only to a requester whose req is 1.
REQ-020 Default priority: requester 0 wins whenever both request.
REQ-021 Starvation counter wait_cnt (3 bits min, saturating at MAX_WAIT): increments each cycle r1_req=1 and r1_gnt=0; clears on an r1 grant or when r1_req=0.
REQ-022 When wait_cnt == MAX_WAIT and r1_req=1, requester 1 is granted regardless of r0_req; r0_gnt=0 that cycle.
REQ-023 Granted in-range access: mem_en=1, mem_we, mem_addr and mem_wdata taken from the granted requester in the same cycle; otherwise mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-024 Granted read issued in cycle T: the corresponding rvalid=1 in cycle T+1 only, with rdata = mem_rdata.
REQ-025 Granted writes produce no rvalid; the write is committed at the edge ending cycle T.
REQ-026 Back-to-back grants are allowed every cycle; a read in T+1 following a write in T to the same address returns the new data.
REQ-027 Out-of-range access (addr >= DEPTH): granted normally, mem_en=0, no memory write; err=1 in cycle T+1 for that requester; for a read, rvalid=1 and rdata=0 in T+1.
REQ-028 Response tracking is registered per requester (pending-read flag, error flag, 1 cycle deep); the granted requester id and the issued read/error status are recorded at each grant edge.
REQ-029 req deasserted without a grant: no access, no response, no state change other than wait_cnt clear.
REQ-030 Simultaneous r0 and r1 requests with wait_cnt < MAX_WAIT: r0 granted, wait_cnt increments.

Reset
REQ-031 While rst=1: all gnt, rvalid, err, mem_en and mem_we outputs are 0, all rdata and mem_* data outputs are 0, wait_cnt=0, pending flags cleared.
REQ-032 Reset asserted with a read pending: the response is discarded; no rvalid is produced after reset releases.
REQ-033 First grant is possible in the first cycle after rst deasserts.

Verification
REQ-034 Write then read: r0 writes 0xDEADBEEF to addr 5, next cycle reads addr 5 -> r0_rvalid=1 with r0_rdata=0xDEADBEEF one cycle after the read grant.
REQ-035 Contention: r0_req and r1_req held high continuously, MAX_WAIT=4 -> grant pattern r0,r0,r0,r0,r1 repeating; r1 is never denied more than 4 consecutive cycles.
REQ-036 Out-of-range: r1 reads addr 128 (DEPTH=128) -> mem_en=0, next cycle r1_err=1, r1_rvalid=1, r1_rdata=0; r1 write to addr 200 leaves memory unchanged.
REQ-037 Pipelined reads: r0 reads addrs 0,1,2 on consecutive cycles (preloaded 0x10,0x11,0x12) -> r0_rvalid high three consecutive cycles with rdata 0x10,0x11,0x12.
REQ-038 Reset mid-operation: rst pulsed in the cycle a read is granted -> no rvalid afterwards, all outputs 0 during reset, wait_cnt restarts at 0.
REQ-039 Single requester: only r1_req=1 -> r1_gnt=1 every cycle, wait_cnt stays 0.
